shift_add_multiplier: RTL

- Sequential unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, using the radix-2 shift-and-add algorithm.
- Consumes the team's parallel-prefix adder: one kogge_stone_adder instance forms each partial sum.
- Sits directly downstream of that adder in the arithmetic library.
- Valid/ready handshake on both operand input and product output. One multiplication in flight at a time.

---
 rtl/mult_pkg.sv | 16 +
 rtl/kogge_stone_adder.sv | 46 ++++
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the step-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/kogge_stone_adder.sv
// Parallel-prefix (Kogge-Stone) adder: WIDTH-bit sum plus carry-out.
// Each prefix level lives in its own generate scope so no vector feeds itself.
module kogge_stone_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int LVL = $clog2(WIDTH);

    logic [WIDTH:0] carry;

    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;

        if (k == 0) begin : g_init
            assign gg = a_i & b_i;
            assign pp = a_i ^ b_i;
        end else begin : g_comb
            localparam int DIST = 1 << (k - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= DIST) begin : g_merge
                    assign gg[i] = g_lvl[k-1].gg[i]
                                 | (g_lvl[k-1].pp[i] & g_lvl[k-1].gg[i-DIST]);
                    assign pp[i] = g_lvl[k-1].pp[i] & g_lvl[k-1].pp[i-DIST];
                end else begin : g_pass
                    assign gg[i] = g_lvl[k-1].gg[i];
                    assign pp[i] = g_lvl[k-1].pp[i];
                end
            end
        end
    end

    // After the last level gg/pp span bit 0..i, so cin folds in with one AND-OR.
    assign carry[0]       = cin_i;
    assign carry[WIDTH:1] = g_lvl[LVL].gg | (g_lvl[LVL].pp & {WIDTH{cin_i}});

    assign sum_o  = g_lvl[0].pp ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Optional SHIFT_ADD_MULT_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   psum;
    logic               pcarry;

    assign addend = mplier_q[0] ? mcand_q : '0;

    kogge_stone_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (psum),
        .cout_o (pcarry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
                    if (a == '0 || b == '0) begin
                        mplier_d = '0;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                // {carry, sum, mplier} >> 1: the carry lands in the acc MSB.
                acc_d    = {pcarry, psum[WIDTH-1:1]};
                mplier_d = {psum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign product   = {acc_q, mplier_q};

endmodule
